// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: bridges EX/MEM pipeline outputs to a req/gnt/rvalid data bus.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of truncating the address.
module mau_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size_i,
  input  logic [1:0] off_i,
  input  logic [7:0] b_i,
  input  logic [7:0] h_i,
  input  logic [7:0] w_i,
  output logic       be_o,
  output logic [7:0] wbyte_o
);
  localparam logic [1:0] L = LANE[1:0];

  always_comb begin
    case (size_i)
      2'd0:    begin be_o = (off_i == L);                      wbyte_o = b_i; end
      2'd1:    begin be_o = ((off_i & 2'b10) == (L & 2'b10));  wbyte_o = h_i; end
      default: begin be_o = 1'b1;                              wbyte_o = w_i; end
    endcase
  end
endmodule

module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             mem_op_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [31:0]            mem_data_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [31:0]            reg_wdata_i,
  output logic                   stall_o,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [31:0]            dbus_wdata_o,
  output logic [3:0]             dbus_be_o,
  input  logic                   dbus_gnt_i,
  input  logic                   dbus_rvalid_i,
  input  logic [31:0]            dbus_rdata_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [31:0]            reg_wdata_o,
  output logic                   misalign_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-3:0]   waddr_q, waddr_d;
  logic                    we_q, we_d, sign_q, sign_d;
  logic [1:0]              size_q, size_d, off_q, off_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [RADDR_WIDTH-1:0]  rwa_q, rwa_d;
  logic                    rwe_q, rwe_d;
  logic [31:0]             rwd_q, rwd_d;

  logic       unused_we;
  logic       is_mem, is_store, op_sign;
  logic [1:0] op_size, op_off;

  assign unused_we = mem_we_i;

  // size: 0 byte, 1 half, 2 word; offset is forced to natural alignment
  always_comb begin
    is_mem   = (mem_op_i <= 4'd7);
    is_store = is_mem && (mem_op_i >= 4'd5);
    op_sign  = (mem_op_i == 4'd0) || (mem_op_i == 4'd1);
    case (mem_op_i)
      4'd0, 4'd3, 4'd5: op_size = 2'd0;
      4'd1, 4'd4, 4'd6: op_size = 2'd1;
      default:          op_size = 2'd2;
    endcase
    case (op_size)
      2'd0:    op_off = mem_addr_i[1:0];
      2'd1:    op_off = {mem_addr_i[1], 1'b0};
      default: op_off = 2'b00;
    endcase
  end

  logic [3:0]      lane_be;
  logic [3:0][7:0] lane_wb;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    mau_lane #(.LANE(l)) u_lane (
      .size_i  (op_size),
      .off_i   (op_off),
      .b_i     (mem_data_i[7:0]),
      .h_i     (mem_data_i[8*(l%2) +: 8]),
      .w_i     (mem_data_i[8*l +: 8]),
      .be_o    (lane_be[l]),
      .wbyte_o (lane_wb[l])
    );
  end

  logic [31:0] ld_sh, ld_data;

  always_comb begin
    ld_sh = dbus_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld_data = {{24{sign_q & ld_sh[7]}},  ld_sh[7:0]};
      2'd1:    ld_data = {{16{sign_q & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_data = ld_sh;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d, op_mis;
  assign op_mis     = ((op_size == 2'd1) && mem_addr_i[0]) ||
                      ((op_size == 2'd2) && (mem_addr_i[1:0] != 2'b00));
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    sign_d  = sign_q;
    size_d  = size_q;
    off_d   = off_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rwa_d   = rwa_q;
    rwe_d   = rwe_q;
    rwd_d   = rwd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    stall_o    = 1'b0;
    dbus_req_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          stall_o = 1'b1;
          waddr_d = mem_addr_i[ADDR_WIDTH-1:2];
          we_d    = is_store;
          sign_d  = op_sign;
          size_d  = op_size;
          off_d   = op_off;
          be_d    = lane_be;
          wdata_d = lane_wb;
          rwe_d   = 1'b0;
          state_d = S_REQ;
`ifdef MEM_MISALIGN_TRAP_EN
          if (op_mis) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end else begin
          rwa_d = reg_waddr_i;
          rwe_d = reg_we_i;
          rwd_d = reg_wdata_i;
        end
      end
      S_REQ: begin
        stall_o    = 1'b1;
        dbus_req_o = 1'b1;
        if (dbus_gnt_i) begin
          state_d = we_q ? S_DONE : S_WAIT;
          if (we_q) begin
            rwa_d = reg_waddr_i;
            rwe_d = reg_we_i;
            rwd_d = reg_wdata_i;
          end
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (dbus_rvalid_i) begin
          rwa_d   = reg_waddr_i;
          rwe_d   = reg_we_i;
          rwd_d   = ld_data;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rwe_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst_i) stall_o = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      be_q    <= 4'd0;
      wdata_q <= '0;
      rwa_q   <= '0;
      rwe_q   <= 1'b0;
      rwd_q   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      sign_q  <= sign_d;
      size_q  <= size_d;
      off_q   <= off_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rwa_q   <= rwa_d;
      rwe_q   <= rwe_d;
      rwd_q   <= rwd_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = {waddr_q, 2'b00};
  assign dbus_wdata_o = wdata_q;
  assign dbus_be_o    = be_q;
  assign reg_waddr_o  = rwa_q;
  assign reg_we_o     = rwe_q;
  assign reg_wdata_o  = rwd_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_op_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i, reg_wdata_i, dbus_rdata_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i, dbus_gnt_i, dbus_rvalid_i;
  logic        stall_o, dbus_req_o, dbus_we_o, reg_we_o, misalign_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, reg_wdata_o;
  logic [3:0]  dbus_be_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int errors = 0;
  bit trap;

  mem_access_unit #(.ADDR_WIDTH(32), .RADDR_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst), .mem_op_i(mem_op_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .reg_waddr_i(reg_waddr_i),
    .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i), .stall_o(stall_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, naturally aligned offset
  function automatic int unsigned nbytes(input logic [3:0] op);
    case (op)
      4'd0, 4'd3, 4'd5: return 1;
      4'd1, 4'd4, 4'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic int unsigned eff_off(input logic [3:0] op, input logic [31:0] addr);
    int unsigned o = addr % 4;
    return o - (o % nbytes(op));
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
    int unsigned v = ((1 << nbytes(op)) - 1) << eff_off(op, addr);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] data);
    int unsigned n = nbytes(op);
    longint unsigned mask = (64'd1 << (8 * n)) - 1;
    longint unsigned r = 0;
    for (int i = 0; i < 4; i += n) r |= ({32'd0, data} & mask) << (8 * i);
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int unsigned n = nbytes(op);
    longint unsigned mask = (64'd1 << (8 * n)) - 1;
    longint unsigned v = ({32'd0, rdata} >> (8 * eff_off(op, addr))) & mask;
    if ((op == 4'd0 || op == 4'd1) && ((v >> (8 * n - 1)) & 1) == 1) v |= ~mask;
    return v[31:0];
  endfunction

  task automatic drive_nop();
    mem_op_i = 4'd8; mem_we_i = 1'b0; reg_we_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
  endtask

  // One memory instruction from the IDLE detect cycle through the post-DONE bubble.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int gd, input int rd, input logic we);
    bit ld  = (op <= 4'd4);
    bit mis = trap && ((addr % 4) != eff_off(op, addr));
    logic [4:0]  wa  = 5'($urandom);
    logic [31:0] alu = $urandom;
    mem_op_i = op; mem_we_i = !ld; mem_addr_i = addr; mem_data_i = data;
    reg_waddr_i = wa; reg_we_i = we; reg_wdata_i = alu;
    #1;
    chk("detect_stall", stall_o, 1);
    chk("detect_req", dbus_req_o, 0);
    @(posedge clk); #1;
    if (mis) begin
      chk("trap_mis", misalign_o, 1);
      chk("trap_we", reg_we_o, 0);
      chk("trap_req", dbus_req_o, 0);
      chk("trap_stall", stall_o, 0);
    end else begin
      for (int d = 0; d <= gd; d++) begin
        chk("req_req", dbus_req_o, 1);
        chk("req_stall", stall_o, 1);
        chk("req_addr", dbus_addr_o, addr & 32'hFFFF_FFFC);
        chk("req_we", dbus_we_o, !ld);
        if (!ld) begin
          chk("req_be", dbus_be_o, m_be(op, addr));
          chk("req_wdata", dbus_wdata_o, m_wdata(op, data));
        end
        dbus_gnt_i = (d == gd);
        @(posedge clk); #1;
        dbus_gnt_i = 1'b0;
      end
      if (ld) begin
        for (int d = 0; d <= rd; d++) begin
          chk("wait_stall", stall_o, 1);
          chk("wait_req", dbus_req_o, 0);
          if (d == rd) begin dbus_rvalid_i = 1'b1; dbus_rdata_i = rdata; end
          @(posedge clk); #1;
          dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom;
        end
      end
      chk("done_stall", stall_o, 0);
      chk("done_mis", misalign_o, 0);
      chk("done_we", reg_we_o, we);
      chk("done_waddr", reg_waddr_o, wa);
      chk("done_wdata", reg_wdata_o, ld ? m_load(op, addr, rdata) : alu);
    end
    drive_nop();
    @(posedge clk); #1;
    chk("bubble_we", reg_we_o, 0);
    chk("bubble_mis", misalign_o, 0);
    chk("bubble_stall", stall_o, 0);
  endtask

  initial begin
`ifdef MEM_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    rst = 1'b1;
    drive_nop();
    mem_addr_i = '0; mem_data_i = '0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_req", dbus_req_o, 0);
    chk("rst_we", reg_we_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_waddr", reg_waddr_o, 0);
    chk("rst_mis", misalign_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_mem(4'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b1);   // LW
    do_mem(4'd0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 1'b1);   // LB
    do_mem(4'd3, 32'h103, 32'h0, 32'h80FFFFFF, 1, 2, 1'b1);   // LBU
    do_mem(4'd4, 32'h102, 32'h0, 32'h80FFFFFF, 0, 1, 1'b1);   // LHU
    do_mem(4'd5, 32'h201, 32'hAB, 32'h0, 3, 0, 1'b0);         // SB, late gnt
    do_mem(4'd7, 32'h302, 32'h12345678, 32'h0, 0, 0, 1'b0);   // SW misaligned
    do_mem(4'd1, 32'h105, 32'h0, 32'h00008001, 0, 0, 1'b1);   // LH odd address

    // Non-memory stream
    for (int k = 0; k < 3; k++) begin
      logic [4:0]  wa = 5'($urandom);
      logic [31:0] wd = $urandom | 32'h1;
      mem_op_i = 4'd8; reg_we_i = 1'b1; reg_waddr_i = wa; reg_wdata_i = wd;
      #1;
      chk("alu_stall", stall_o, 0);
      chk("alu_req", dbus_req_o, 0);
      @(posedge clk); #1;
      chk("alu_we", reg_we_o, 1);
      chk("alu_waddr", reg_waddr_o, wa);
      chk("alu_wdata", reg_wdata_o, wd);
    end

    // Reset while waiting for read data; the late rvalid must be dropped
    mem_op_i = 4'd2; mem_addr_i = 32'h400; reg_we_i = 1'b1; reg_waddr_i = 5'd7;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b1;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b0;
    chk("wr_stall", stall_o, 1);
    rst = 1'b1;
    #1;
    chk("wr_rst_stall", stall_o, 0);
    chk("wr_rst_wdata", reg_wdata_o, 0);
    chk("wr_rst_waddr", reg_waddr_o, 0);
    chk("wr_rst_we", reg_we_o, 0);
    drive_nop();
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dbus_rvalid_i = 1'b0;
    chk("wr_post_we", reg_we_o, 0);
    chk("wr_post_wdata", reg_wdata_o, 0);
    chk("wr_post_stall", stall_o, 0);
    chk("wr_post_req", dbus_req_o, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      do_mem(4'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
